// File: rtl/kmac_pkg.sv
// kmac_pkg: shared constants, FSM state type and result record for kmac_accum.
// Optional feature macro: KMAC_ACC_SAT_EN (adds the per-sum saturation flag).
package kmac_pkg;

  localparam int OP_W       = 32;
  localparam int PROD_W     = 64;
  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_CNT_W = 2;   // holds 0..FIFO_DEPTH
  localparam int ACC_W_DEF  = 72;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic {
    ACC_IDLE,
    ACC_RUN
  } acc_state_t;

  // Result record at the default widths; kmac_accum builds the same layout at its own widths.
  typedef struct packed {
    logic [ACC_W_DEF-1:0] sum;
    logic [CNT_W_DEF-1:0] count;
`ifdef KMAC_ACC_SAT_EN
    logic                 sat;
`endif
  } result_t;

endpackage

// File: rtl/kmac_result_fifo.sv
// kmac_result_fifo: 2-entry synchronous FIFO of completed sums. The head entry is
// presented combinationally; push and pop in the same cycle are allowed even when full.
module kmac_result_fifo
  import kmac_pkg::*;
#(
  parameter type entry_t = result_t
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  entry_t                i_data,
  input  logic                  i_pop,
  output entry_t                o_head,
  output logic [FIFO_CNT_W-1:0] o_count
);

  entry_t                r_mem [FIFO_DEPTH];
  logic                  r_wptr;
  logic                  r_rptr;
  logic [FIFO_CNT_W-1:0] r_count;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the two entries are reset so the outputs read as zero straight out of reset;
      // larger memories would normally be left unreset.
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= ~r_wptr;
      end
      if (i_pop) r_rptr <= ~r_rptr;
      unique case ({i_push, i_pop})
        2'b10:   r_count <= r_count + FIFO_CNT_W'(1);
        2'b01:   r_count <= r_count - FIFO_CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/kmac_accum.sv
// kmac_accum: pipelined multiply-accumulate around an external combinational multiplier.
// S1 operand register -> S2 product register -> S3 accumulator FSM -> 2-entry result FIFO.
// Optional feature macro: KMAC_ACC_SAT_EN (clamp on carry-out, sticky per-sum out_sat).
module kmac_accum
  import kmac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  input  logic              in_last,
  output logic [OP_W-1:0]   mul_a,
  output logic [OP_W-1:0]   mul_b,
  input  logic [PROD_W-1:0] mul_p,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_sat
);

  typedef struct packed {
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] count;
`ifdef KMAC_ACC_SAT_EN
    logic             sat;
`endif
  } acc_result_t;

  // S1 operands
  logic              r_s1_valid;
  logic              r_s1_last;
  logic [OP_W-1:0]   r_mul_a;
  logic [OP_W-1:0]   r_mul_b;
  // S2 product
  logic              r_s2_valid;
  logic              r_s2_last;
  logic [PROD_W-1:0] r_s2_prod;
  // S3 accumulator
  acc_state_t        r_state;
  acc_state_t        w_state_nxt;
  logic [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic [ACC_W-1:0]  w_acc_base;
  logic [ACC_W-1:0]  w_prod_ext;
  logic [ACC_W-1:0]  w_acc_nxt;
  logic [CNT_W-1:0]  w_cnt_base;
  logic [CNT_W-1:0]  w_cnt_nxt;
`ifdef KMAC_ACC_SAT_EN
  logic              r_sat;
  logic              w_sat_nxt;
  logic [ACC_W:0]    w_add;
`endif
  // Handshake, credits and FIFO
  logic              w_in_fire;
  logic [2:0]        w_reserved;
  logic              w_push;
  logic              w_pop;
  acc_result_t       w_push_entry;
  acc_result_t       w_head;
  logic [FIFO_CNT_W-1:0] w_fifo_count;

  // A last beat reserves a FIFO slot from acceptance until it lands, so S3 never stalls.
  assign w_reserved = {1'b0, w_fifo_count} + {2'b00, r_s1_last} + {2'b00, r_s2_last};
  assign in_ready   = !rst && (w_reserved < 3'd2);
  assign w_in_fire  = in_valid && in_ready;

  // S1: capture accepted operands; they feed the multiplier directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples
      // pre-edge values regardless of block ordering.
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_mul_a    <= '0;
      r_mul_b    <= '0;
    end else begin
      r_s1_valid <= w_in_fire;
      r_s1_last  <= w_in_fire && in_last;
      if (w_in_fire) begin
        r_mul_a <= in_a;
        r_mul_b <= in_b;
      end
    end
  end

  assign mul_a = r_mul_a;
  assign mul_b = r_mul_b;

  // S2: register the multiplier product one cycle after the operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_prod  <= '0;
    end else begin
      r_s2_valid <= r_s1_valid;
      r_s2_last  <= r_s1_last;
      if (r_s1_valid) r_s2_prod <= mul_p;
    end
  end

  // S3 arithmetic: an idle accumulator behaves as zero so the first product loads it.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_prod_ext = ACC_W'(r_s2_prod);
    w_acc_base = (r_state == ACC_RUN) ? r_acc : '0;
    w_cnt_base = (r_state == ACC_RUN) ? r_cnt : '0;
    w_cnt_nxt  = (&w_cnt_base) ? w_cnt_base : w_cnt_base + CNT_W'(1);
`ifdef KMAC_ACC_SAT_EN
    w_add      = {1'b0, w_acc_base} + {1'b0, w_prod_ext};
    w_acc_nxt  = w_add[ACC_W] ? '1 : w_add[ACC_W-1:0];
    w_sat_nxt  = ((r_state == ACC_RUN) && r_sat) || w_add[ACC_W];
`else
    w_acc_nxt  = w_acc_base + w_prod_ext;
`endif
  end

  // S3 FSM next state and FIFO push of the completed sum.
  always_comb begin
    w_state_nxt  = r_state;
    w_push       = 1'b0;
    w_push_entry = '0;
    w_push_entry.sum   = w_acc_nxt;
    w_push_entry.count = w_cnt_nxt;
`ifdef KMAC_ACC_SAT_EN
    w_push_entry.sat   = w_sat_nxt;
`endif
    if (r_s2_valid) begin
      if (r_s2_last) begin
        w_push      = 1'b1;
        w_state_nxt = ACC_IDLE;
      end else begin
        w_state_nxt = ACC_RUN;
      end
    end
  end

  // S3 state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ACC_IDLE;
    else     r_state <= w_state_nxt;
  end

  // S3 accumulator registers: cleared when a sum closes, updated on every other product.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
`ifdef KMAC_ACC_SAT_EN
      r_sat <= 1'b0;
`endif
    end else if (r_s2_valid) begin
      if (r_s2_last) begin
        r_acc <= '0;
        r_cnt <= '0;
`ifdef KMAC_ACC_SAT_EN
        r_sat <= 1'b0;
`endif
      end else begin
        r_acc <= w_acc_nxt;
        r_cnt <= w_cnt_nxt;
`ifdef KMAC_ACC_SAT_EN
        r_sat <= w_sat_nxt;
`endif
      end
    end
  end

  assign w_pop = out_valid && out_ready;

  kmac_result_fifo #(
    .entry_t (acc_result_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_fifo_count)
  );

  assign out_valid = (w_fifo_count != '0);
  assign out_sum   = w_head.sum;
  assign out_count = w_head.count;
`ifdef KMAC_ACC_SAT_EN
  assign out_sat   = w_head.sat;
`else
  assign out_sat   = 1'b0;
`endif

endmodule

// File: tb/tb_kmac_accum.sv
// tb_kmac_accum: directed bench for kmac_accum. A 72-bit instance takes every beat; a
// 64-bit instance with a 2-bit counter joins in for the wrap/saturation sequences.
// Optional feature macro: KMAC_ACC_SAT_EN (changes the expected 64-bit overflow result).
module tb_kmac_accum;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_last, out_ready, sel64;
  logic [31:0] in_a, in_b;

  logic        in_ready, out_valid, out_sat;
  logic [31:0] mul_a, mul_b;
  logic [63:0] mul_p;
  logic [71:0] out_sum;
  logic [15:0] out_count;

  logic        in_valid64, in_ready64, out_valid64, out_sat64;
  logic [31:0] mul_a64, mul_b64;
  logic [63:0] mul_p64;
  logic [63:0] out_sum64;
  logic [1:0]  out_count64;

  // External combinational multipliers.
  assign mul_p      = {32'b0, mul_a} * {32'b0, mul_b};
  assign mul_p64    = {32'b0, mul_a64} * {32'b0, mul_b64};
  assign in_valid64 = in_valid && sel64;

  kmac_accum u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .mul_a(mul_a), .mul_b(mul_b),
    .mul_p(mul_p), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_count(out_count), .out_sat(out_sat)
  );

  kmac_accum #(.ACC_W(64), .CNT_W(2)) u_dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid64), .in_ready(in_ready64),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .mul_a(mul_a64), .mul_b(mul_b64),
    .mul_p(mul_p64), .out_valid(out_valid64), .out_ready(out_ready),
    .out_sum(out_sum64), .out_count(out_count64), .out_sat(out_sat64)
  );

  typedef struct {
    logic [127:0] sum;
    logic [127:0] count;
    logic         sat;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        last;
    logic [71:0] exp_sum;
    int          exp_cnt;
  } vec_t;

  localparam int NV = 12;
  localparam logic [63:0] FF2 = 64'hFFFF_FFFE_0000_0001;

  res_t q72[$];
  res_t q64[$];
  int   checks   = 0;
  int   failures = 0;
  int   fifo_max = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Result monitor, sampled well clear of both clock edges and of stimulus changes.
  always begin
    res_t r;
    @(negedge clk);
    #3;
    if (!rst && out_valid && out_ready) begin
      r.sum = 128'(out_sum); r.count = 128'(out_count); r.sat = out_sat;
      q72.push_back(r);
    end
    if (!rst && out_valid64 && out_ready) begin
      r.sum = 128'(out_sum64); r.count = 128'(out_count64); r.sat = out_sat64;
      q64.push_back(r);
    end
    if (int'(u_dut.w_fifo_count) > fifo_max) fifo_max = int'(u_dut.w_fifo_count);
  end

  // Present one beat and hold it until accepted (bounded); returns on the following negedge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic last);
    int n = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
    #1;
    while (!(in_ready && (in_ready64 || !sel64)) && n < 100) begin
      @(negedge clk); #1; n++;
    end
    check("send_ready", 128'(in_ready), 128'(1));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Wait (bounded) for the expected number of results, then confirm no extras appear.
  task automatic wait_res(input int n72, input int n64);
    int n = 0;
    while ((q72.size() < n72 || q64.size() < n64) && n < 100) begin
      @(negedge clk); n++;
    end
    repeat (4) @(negedge clk);
    check("nres72", 128'(q72.size()), 128'(n72));
    check("nres64", 128'(q64.size()), 128'(n64));
  endtask

  vec_t vecs [NV];
  res_t exp_q[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{32'd3,          32'd5,          1'b1, 72'd15,                    1};
    vecs[1]  = '{32'd1,          32'd2,          1'b0, 72'd0,                     0};
    vecs[2]  = '{32'd3,          32'd4,          1'b0, 72'd0,                     0};
    vecs[3]  = '{32'd5,          32'd6,          1'b0, 72'd0,                     0};
    vecs[4]  = '{32'd7,          32'd8,          1'b1, 72'd100,                   4};
    vecs[5]  = '{32'd0,          32'd0,          1'b1, 72'd0,                     1};
    vecs[6]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 72'd0,                     0};
    vecs[7]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 72'd0,                     0};
    vecs[8]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 72'h2_FFFF_FFFA_0000_0003, 3};
    vecs[9]  = '{32'h0001_0000,  32'h0001_0000,  1'b0, 72'd0,                     0};
    vecs[10] = '{32'd1,          32'd1,          1'b1, 72'h1_0000_0001,           2};
    vecs[11] = '{32'hFFFF_FFFF,  32'd2,          1'b1, 72'h1_FFFF_FFFE,           1};

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_a = '0; in_b = '0;
    out_ready = 1'b0; sel64 = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready",  128'(in_ready),   128'(0));
    check("rst_mul_a",     128'(mul_a),      128'(0));
    check("rst_mul_b",     128'(mul_b),      128'(0));
    check("rst_out_valid", 128'(out_valid),  128'(0));
    check("rst_out_sum",   128'(out_sum),    128'(0));
    check("rst_out_count", 128'(out_count),  128'(0));
    check("rst_out_sat",   128'(out_sat),    128'(0));
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 128'(in_ready), 128'(1));
    @(negedge clk);

    // Single-beat sum: latency and held output
    send(32'd3, 32'd5, 1'b1);
    check("lat_e0_valid", 128'(out_valid), 128'(0));
    @(negedge clk);
    check("lat_e1_valid", 128'(out_valid), 128'(0));
    @(negedge clk);
    check("lat_e2_valid", 128'(out_valid), 128'(1));
    check("single_sum",   128'(out_sum),   128'(15));
    check("single_count", 128'(out_count), 128'(1));
    check("single_sat",   128'(out_sat),   128'(0));
    @(negedge clk);
    check("single_hold",  128'(out_sum),   128'(15));
    out_ready = 1'b1;
    @(negedge clk);
    check("single_popped", 128'(out_valid), 128'(0));
    check("single_nres",   128'(q72.size()), 128'(1));
    q72.delete(); q64.delete();

    // Table-driven sums with out_ready held high
    exp_q.delete();
    for (int i = 0; i < NV; i++) begin
      res_t e;
      send(vecs[i].a, vecs[i].b, vecs[i].last);
      if (vecs[i].last) begin
        e.sum = 128'(vecs[i].exp_sum); e.count = 128'(vecs[i].exp_cnt); e.sat = 1'b0;
        exp_q.push_back(e);
      end
    end
    wait_res(exp_q.size(), 0);
    for (int i = 0; i < exp_q.size() && i < q72.size(); i++) begin
      check($sformatf("tbl_sum[%0d]", i),   q72[i].sum,        exp_q[i].sum);
      check($sformatf("tbl_count[%0d]", i), q72[i].count,      exp_q[i].count);
      check($sformatf("tbl_sat[%0d]", i),   128'(q72[i].sat),  128'(0));
    end
    q72.delete(); q64.delete();

    // Backpressure: two lasts fill the credits, in_ready drops, FIFO holds both
    out_ready = 1'b0;
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    check("bp_ready_after2", 128'(in_ready), 128'(0));
    repeat (3) @(negedge clk);
    check("bp_ready_full",  128'(in_ready),              128'(0));
    check("bp_fifo_count",  128'(u_dut.w_fifo_count),    128'(2));
    check("bp_out_valid",   128'(out_valid),             128'(1));
    check("bp_head_sum",    128'(out_sum),               128'(FF2));
    check("bp_no_pop",      128'(q72.size()),            128'(0));
    out_ready = 1'b1;
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_res(4, 0);
    for (int i = 0; i < q72.size(); i++) begin
      check($sformatf("bp_sum[%0d]", i),   q72[i].sum,   128'(FF2));
      check($sformatf("bp_count[%0d]", i), q72[i].count, 128'(1));
    end
    q72.delete(); q64.delete();

    // Overflow: wraps (or clamps) at 64 bits, fits at 72 bits
    sel64 = 1'b1;
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_res(1, 1);
    if (q72.size() > 0) begin
      check("ovf72_sum",   q72[0].sum,        128'h1_FFFF_FFFC_0000_0002);
      check("ovf72_count", q72[0].count,      128'(2));
      check("ovf72_sat",   128'(q72[0].sat),  128'(0));
    end
    if (q64.size() > 0) begin
`ifdef KMAC_ACC_SAT_EN
      check("ovf64_sum",   q64[0].sum,        128'hFFFF_FFFF_FFFF_FFFF);
      check("ovf64_sat",   128'(q64[0].sat),  128'(1));
`else
      check("ovf64_sum",   q64[0].sum,        128'hFFFF_FFFC_0000_0002);
      check("ovf64_sat",   128'(q64[0].sat),  128'(0));
`endif
      check("ovf64_count", q64[0].count,      128'(2));
    end
    q72.delete(); q64.delete();

    // Beat counter saturates on the 2-bit instance; sat flag starts clear on a new sum
    for (int i = 0; i < 5; i++) send(32'd1, 32'd1, (i == 4));
    wait_res(1, 1);
    if (q64.size() > 0) begin
      check("csat64_sum",   q64[0].sum,        128'(5));
      check("csat64_count", q64[0].count,      128'(3));
      check("csat64_sat",   128'(q64[0].sat),  128'(0));
    end
    if (q72.size() > 0) check("csat72_count", q72[0].count, 128'(5));
    q72.delete(); q64.delete();
    sel64 = 1'b0;

    // Reset mid-sum discards the open sum and in-flight beats
    for (int i = 0; i < 3; i++) send(32'd10, 32'd10, 1'b0);
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 128'(in_ready), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_valid", 128'(out_valid), 128'(0));
    send(32'd2, 32'd2, 1'b1);
    wait_res(1, 0);
    if (q72.size() > 0) begin
      check("mid_rst_sum",   q72[0].sum,   128'(4));
      check("mid_rst_count", q72[0].count, 128'(1));
    end
    q72.delete(); q64.delete();

    // Full FIFO drained while single-beat sums keep arriving
    out_ready = 1'b0;
    send(32'd1, 32'd1, 1'b1);
    send(32'd2, 32'd2, 1'b1);
    repeat (3) @(negedge clk);
    check("pp_fifo_full", 128'(u_dut.w_fifo_count), 128'(2));
    fifo_max  = 0;
    out_ready = 1'b1;
    for (int k = 3; k <= 8; k++) send(32'(k), 32'(k), 1'b1);
    wait_res(8, 0);
    check("pp_fifo_max", 128'(fifo_max), 128'(2));
    for (int i = 0; i < q72.size(); i++) begin
      check($sformatf("pp_sum[%0d]", i),   q72[i].sum,   128'((i + 1) * (i + 1)));
      check($sformatf("pp_count[%0d]", i), q72[i].count, 128'(1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
